// File: rtl/command_receiver_pkg.sv
// command_receiver_pkg
//   Shared definitions for the command receiver slice: state encodings for
//   the UART bit FSM, the command assembly FSM and the dispatch FSM, the
//   bit-period derivation, the reserved-bit mask for the address byte and
//   (with RX_PARITY_EN) the even-parity helper.
//   Optional feature macro: RX_PARITY_EN (8E1 framing instead of 8N1).
package command_receiver_pkg;

  typedef enum logic [2:0] {
    B_IDLE   = 3'd0,
    B_START  = 3'd1,
    B_DATA   = 3'd2,
    B_STOP   = 3'd3
`ifdef RX_PARITY_EN
    ,
    B_PARITY = 3'd4
`endif
  } bit_state_t;

  typedef enum logic {
    A_ADDR = 1'b0,
    A_REQ  = 1'b1
  } asm_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_WAIT = 1'b1
  } disp_state_t;

  // Bits [7:5] of an address byte must be zero (sensor index is 0..31).
  localparam logic [7:0] ADDR_RSVD_MASK = 8'hE0;

  // Whole clock cycles per UART bit; callers must keep the result >= 4.
  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

`ifdef RX_PARITY_EN
  // Parity bit value that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   UART byte receiver: 2-flop synchronizer on rx, start-bit qualification at
//   mid-bit, 8 data bits LSB first, stop bit check. A bad stop bit drops the
//   byte, pulses byte_frame_error and waits for the line to return high.
//   Optional feature macro: RX_PARITY_EN adds an even parity bit after bit 7;
//   a parity mismatch is treated exactly like a bad stop bit.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   rx                asynchronous serial line, idle high
//   byte_data         received byte, valid while byte_valid is high
//   byte_valid        one-cycle pulse, byte received correctly
//   byte_frame_error  one-cycle pulse, framing (or parity) error
//   line_idle         bit FSM is waiting for a start bit
module uart_rx_byte
  import command_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_frame_error,
  output logic       line_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  bit_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             wait_high_r;
  logic [7:0]       byte_data_r;
  logic             byte_valid_r;
  logic             frame_err_r;
  logic             stop_ok_s;
`ifdef RX_PARITY_EN
  logic             parity_bad_r;

  assign stop_ok_s = sync2_r && !parity_bad_r;
`else
  assign stop_ok_s = sync2_r;
`endif

  assign byte_data        = byte_data_r;
  assign byte_valid       = byte_valid_r;
  assign byte_frame_error = frame_err_r;
  assign line_idle        = (state_r == B_IDLE);

  // Synchronize rx and keep the previous synchronized value for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Bit-level FSM: start qualification, data shifting, stop/parity checking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= B_IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      wait_high_r  <= 1'b0;
      byte_data_r  <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bad_r <= 1'b0;
`endif
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        B_IDLE: begin
          cnt_r <= '0;
          if (prev_r && !sync2_r) begin
            state_r <= B_START;
          end
        end
        B_START: begin
          // A low that does not last to mid-bit is a glitch, not a start bit.
          if (cnt_r == HALF_LAST) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            state_r   <= sync2_r ? B_IDLE : B_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        B_DATA: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
`ifdef RX_PARITY_EN
              state_r <= B_PARITY;
`else
              state_r <= B_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef RX_PARITY_EN
        B_PARITY: begin
          if (cnt_r == FULL_LAST) begin
            cnt_r        <= '0;
            parity_bad_r <= (sync2_r != even_parity(shift_r));
            state_r      <= B_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`endif
        B_STOP: begin
          if (wait_high_r) begin
            // After a framing error, do not hunt for a new start bit until
            // the line has gone back to idle.
            if (sync2_r) begin
              wait_high_r <= 1'b0;
              state_r     <= B_IDLE;
            end
          end else if (cnt_r == FULL_LAST) begin
            cnt_r <= '0;
            if (stop_ok_s) begin
              byte_data_r  <= shift_r;
              byte_valid_r <= 1'b1;
              state_r      <= B_IDLE;
            end else begin
              frame_err_r <= 1'b1;
              if (sync2_r) begin
                state_r <= B_IDLE;
              end else begin
                wait_high_r <= 1'b1;
              end
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= B_IDLE;
          wait_high_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/command_receiver.sv
// command_receiver
//   Upstream stage of the sensor decoder facade. Receives UART bytes, pairs
//   them into (address, request) commands, buffers one pending command and
//   issues commands to the decoder one at a time, waiting for finished.
//   Optional feature macro: RX_PARITY_EN (8E1 framing, see uart_rx_byte).
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   rx            asynchronous UART serial line, idle high
//   finished      one-cycle pulse from decoder, current command done
//   enable        one-cycle pulse, request/address valid
//   request       request code of the issued command (held until next issue)
//   address       sensor index of the issued command (held until next issue)
//   frame_error   one-cycle pulse: bad stop/parity bit or reserved address bits
//   timeout       one-cycle pulse: request byte did not arrive in time
//   overrun       one-cycle pulse: command dropped, pending slot full
module command_receiver
  import command_receiver_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       finished,
  output logic       enable,
  output logic [7:0] request,
  output logic [4:0] address,
  output logic       frame_error,
  output logic       timeout,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [7:0]       byte_data_s;
  logic             byte_valid_s;
  logic             byte_frame_error_s;
  logic             line_idle_s;
  logic             addr_bad_s;
  logic             cmd_done_s;
  logic             drain_s;

  asm_state_t       asm_state_r;
  logic [4:0]       addr_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             slot_full_r;
  logic [7:0]       slot_req_r;
  logic [4:0]       slot_addr_r;
  disp_state_t      disp_state_r;
  logic             enable_r;
  logic [7:0]       request_r;
  logic [4:0]       address_r;
  logic             frame_error_r;
  logic             timeout_r;
  logic             overrun_r;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock           (clock),
    .reset           (reset),
    .rx              (rx),
    .byte_data       (byte_data_s),
    .byte_valid      (byte_valid_s),
    .byte_frame_error(byte_frame_error_s),
    .line_idle       (line_idle_s)
  );

  assign addr_bad_s = (asm_state_r == A_ADDR) && byte_valid_s &&
                      ((byte_data_s & ADDR_RSVD_MASK) != 8'h00);
  assign cmd_done_s = (asm_state_r == A_REQ) && byte_valid_s;
  assign drain_s    = (disp_state_r == D_IDLE) && slot_full_r;

  assign enable      = enable_r;
  assign request     = request_r;
  assign address     = address_r;
  assign frame_error = frame_error_r;
  assign timeout     = timeout_r;
  assign overrun     = overrun_r;

  // Command assembly: address byte, then request byte within the timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      asm_state_r   <= A_ADDR;
      addr_r        <= 5'd0;
      tmo_cnt_r     <= '0;
      frame_error_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      frame_error_r <= byte_frame_error_s || addr_bad_s;
      timeout_r     <= 1'b0;
      case (asm_state_r)
        A_ADDR: begin
          tmo_cnt_r <= '0;
          if (byte_valid_s && !addr_bad_s) begin
            addr_r      <= byte_data_s[4:0];
            asm_state_r <= A_REQ;
          end
        end
        A_REQ: begin
          if (byte_valid_s || byte_frame_error_s) begin
            asm_state_r <= A_ADDR;
          end else if (line_idle_s) begin
            // Only idle-line time counts; a byte in flight cannot time out.
            if (tmo_cnt_r == TMO_LAST) begin
              timeout_r   <= 1'b1;
              asm_state_r <= A_ADDR;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            end
          end
        end
        default: begin
          asm_state_r <= A_ADDR;
        end
      endcase
    end
  end

  // One-deep pending slot; a drain in the same cycle makes room for a refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_full_r <= 1'b0;
      slot_req_r  <= 8'h00;
      slot_addr_r <= 5'd0;
      overrun_r   <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (cmd_done_s) begin
        if (slot_full_r && !drain_s) begin
          overrun_r <= 1'b1;
        end else begin
          slot_full_r <= 1'b1;
          slot_req_r  <= byte_data_s;
          slot_addr_r <= addr_r;
        end
      end else if (drain_s) begin
        slot_full_r <= 1'b0;
      end
    end
  end

  // Dispatch: issue one command, then hold off until the decoder finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_state_r <= D_IDLE;
      enable_r     <= 1'b0;
      request_r    <= 8'h00;
      address_r    <= 5'd0;
    end else begin
      enable_r <= 1'b0;
      case (disp_state_r)
        D_IDLE: begin
          if (slot_full_r) begin
            enable_r     <= 1'b1;
            request_r    <= slot_req_r;
            address_r    <= slot_addr_r;
            disp_state_r <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (finished) begin
            disp_state_r <= D_IDLE;
          end
        end
        default: begin
          disp_state_r <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/command_receiver.md
Name: command_receiver

Overview:
- Upstream stage of the sensor decoder facade.
- Deserializes 8N1 UART bytes from the host and assembles 2-byte commands: byte 0 is the sensor address, byte 1 is the request code.
- Issues each command to the decoder as a one-cycle enable pulse with stable request/address, then waits for the decoder's finished pulse before issuing the next command.
- Holds one pending command so the host may pipeline one command ahead.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, UART bit rate.
- TIMEOUT_CYCLES, 2_500_000, maximum idle cycles between byte 0 stop bit and byte 1 start bit.
- Derived constant CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division); must be ≥ 4.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART serial line, idle high.
- finished  input  1  one-cycle pulse from decoder: current command done.
- enable  output  1  one-cycle pulse: request/address valid, start decoder.
- request  output  8  request code of the issued command.
- address  output  5  sensor index 0..31 of the issued command.
- frame_error  output  1  one-cycle pulse: bad stop bit, or address byte bits[7:5] ≠ 0.
- timeout  output  1  one-cycle pulse: second byte did not arrive in time.
- overrun  output  1  one-cycle pulse: a command was dropped because the pending slot was full.

Behaviour:
- Reset: all outputs 0; both FSMs idle; pending slot empty; partial byte discarded. Reset mid-frame or mid-wait aborts everything. The first command after reset is issued without waiting for finished.
- rx input: passes through a 2-flop synchronizer. All detection uses the synchronized value, adding 2 cycles of latency.
- Bit FSM states: B_IDLE, B_START, B_DATA, B_STOP.
  - B_IDLE: a falling edge (synchronized 1→0) loads the bit counter and goes to B_START.
  - B_START: at CLKS_PER_BIT/2 cycles, rx must still be 0; otherwise the start is false and the FSM returns to B_IDLE silently.
  - B_DATA: samples 8 bits at CLKS_PER_BIT intervals, LSB first.
  - B_STOP: samples once. If 1, the byte is delivered with a one-cycle byte_valid. If 0, frame_error is pulsed, the byte is dropped, and the FSM waits for rx=1 before returning to B_IDLE.
- Byte assembly states: A_ADDR, A_REQ.
  - A_ADDR: on a valid byte, check bits[7:5]. If nonzero, pulse frame_error and stay in A_ADDR. Otherwise latch bits[4:0], go to A_REQ, and clear the timeout counter.
  - A_REQ: counter increments each cycle while the bit FSM is in B_IDLE. When it reaches TIMEOUT_CYCLES, pulse timeout, discard the address, and return to A_ADDR.
  - A_REQ: a valid byte completes the command and returns to A_ADDR.
  - A framing error in A_REQ discards the address and returns to A_ADDR (frame_error only, no timeout pulse).
- Pending slot (1 deep): a completed command is written into the slot.
  - If the slot is full and not being drained in the same cycle, the new command is dropped, overrun pulses, and the old pending command is kept.
  - If the slot is drained and refilled in the same cycle, no overrun occurs.
- Dispatch FSM states: D_IDLE, D_WAIT.
  - D_IDLE with slot full: drive request/address from the slot, set enable=1 for exactly one cycle, clear the slot, go to D_WAIT.
  - D_WAIT: on finished=1, go to D_IDLE; the next issue is no earlier than the following cycle.
  - finished while in D_IDLE is ignored.
  - request/address hold their values until the next issue.
- Latency: stop-bit sample to enable is 2 cycles when the dispatcher is idle (slot write, then issue).

Optional Feature:
- Macro RX_PARITY_EN.
- Defined: frames are 8E1. A parity bit is sampled after bit 7 in state B_PARITY. On even-parity mismatch, frame_error pulses and the byte is dropped, handled exactly like a bad stop bit.
- Undefined: 8N1, no B_PARITY state, and no parity logic is synthesized.

Decomposition:
- Package command_receiver_pkg holds:
  - bit, assembly, and dispatch state encodings;
  - the CLKS_PER_BIT derivation;
  - the address-byte reserved-bit mask (3'b111 on bits[7:5]).
- Sub-module uart_rx_byte contains the synchronizer, bit FSM, and optional parity. It outputs byte_data[7:0], byte_valid, and byte_frame_error.
- Assembly, pending slot, and dispatch stay in the top module.

Test Plan:
All tests use CLOCK_FREQ=1600, BAUD_RATE=100 (16 clocks/bit), TIMEOUT_CYCLES=200.
- Send 0x03 then 0x01 → exactly one enable pulse with address=3, request=0x01. No error pulses.
- Send 0x03, 0x01, then 0x07, 0x02 while finished is held low → first command issued; second waits. Pulse finished → enable the following cycle with address=7, request=0x02.
- While in D_WAIT with slot full, send a third command (0x01, 0x05) → overrun pulses once. After two finished pulses, only the first two commands have been issued.
- Send 0x03 with stop bit forced 0 → frame_error pulses; no enable. Then send a valid pair → it is issued normally. Separately, send 0x23 → frame_error pulses, assembly stays in A_ADDR.
- Send 0x03, then stay idle for 200 cycles → timeout pulses. Next sending 0x04, 0x09 → address=4, request=0x09 (not 3).
- Glitch rx low for 4 cycles → no byte, no error. Assert reset mid-byte 1 → all outputs 0, no enable; a following pair is received correctly.
